// File: rtl/som_pkg.sv
// Shared definitions for the SOM neighbourhood generator: level codes and sweep FSM states.
package som_pkg;

  localparam logic [1:0] LVL_WIN  = 2'b00;
  localparam logic [1:0] LVL_NEAR = 2'b01;
  localparam logic [1:0] LVL_MID  = 2'b10;
  localparam logic [1:0] LVL_FAR  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/som_neighbor_gen_if.sv
// Winner-in / row-out link of the neighbourhood generator; slave is the generator's view.
interface som_neighbor_gen_if #(
  parameter int MAP_W   = 8,
  parameter int COORD_W = 3,
  parameter int RAD_W   = 3
);
  logic                 start;
  logic [COORD_W-1:0]   win_x;
  logic [COORD_W-1:0]   win_y;
  logic                 epoch_clr;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [COORD_W-1:0]   out_row;
  logic [2*MAP_W-1:0]   out_sel;
  logic                 out_last;
  logic [RAD_W-1:0]     radius;

  modport slave (
    input  start, win_x, win_y, epoch_clr, out_ready,
    output in_ready, out_valid, out_row, out_sel, out_last, radius
  );

  modport master (
    output start, win_x, win_y, epoch_clr, out_ready,
    input  in_ready, out_valid, out_row, out_sel, out_last, radius
  );
endinterface

// File: rtl/som_level_calc.sv
// Combinational level code for one map cell from its Chebyshev distance to the winner.
module som_level_calc
  import som_pkg::*;
#(
  parameter int COORD_W = 3,
  parameter int RAD_W   = 3
) (
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] win_x,
  input  logic [COORD_W-1:0] win_y,
  input  logic [RAD_W-1:0]   rs,
  output logic [1:0]         level
);
  localparam int CW = COORD_W + 1;
  localparam int RW = RAD_W + 1;
  localparam int W  = (CW > RW) ? CW : RW;

  logic [CW-1:0] dx;
  logic [CW-1:0] dy;
  logic [CW-1:0] d;
  logic [W-1:0]  d_w;
  logic [W-1:0]  rs_w;
  logic [W-1:0]  rs2_w;

  always_comb begin
    dx    = (row >= win_x) ? (CW'(row) - CW'(win_x)) : (CW'(win_x) - CW'(row));
    dy    = (col >= win_y) ? (CW'(col) - CW'(win_y)) : (CW'(win_y) - CW'(col));
    d     = (dx > dy) ? dx : dy;
    d_w   = W'(d);
    rs_w  = W'(rs);
    // 2*Rs formed one bit wider than the radius so the doubled value cannot wrap
    rs2_w = W'({rs, 1'b0});
    level = LVL_FAR;
    if (d_w == '0)
      level = LVL_WIN;
    else if (d_w <= rs_w)
      level = LVL_NEAR;
    else if (d_w <= rs2_w)
      level = LVL_MID;
  end
endmodule

// File: rtl/som_neighbor_gen.sv
// Sweeps all map rows for a latched winner, emitting packed per-column levels, with decaying radius.
module som_neighbor_gen
  import som_pkg::*;
#(
  parameter int MAP_W     = 8,
  parameter int MAP_H     = 8,
  parameter int COORD_W   = 3,
  parameter int RAD_W     = 3,
  parameter int R_INIT    = 1,
  parameter int R_MIN     = 1,
  parameter int EPOCH_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  som_neighbor_gen_if.slave  bus
);
  localparam int CNT_W = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN + 1) : 1;
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(MAP_H - 1);
  localparam logic [RAD_W-1:0]   RAD_INIT = RAD_W'(R_INIT);
  localparam logic [RAD_W-1:0]   RAD_MIN  = RAD_W'(R_MIN);
  localparam logic [CNT_W-1:0]   CNT_TOP  = CNT_W'(EPOCH_LEN - 1);

  state_t             state;
  logic [CNT_W-1:0]   win_cnt;
  logic [COORD_W-1:0] wx_q;
  logic [COORD_W-1:0] wy_q;
  logic [RAD_W-1:0]   rs_q;

  logic               accept;
  logic               hs;
  logic               last_hs;
  logic [RAD_W-1:0]   acc_rs;
  logic [COORD_W-1:0] calc_row;
  logic [COORD_W-1:0] calc_x;
  logic [COORD_W-1:0] calc_y;
  logic [RAD_W-1:0]   calc_rs;
  logic [1:0]         lvl [MAP_W];
  logic [2*MAP_W-1:0] sel_next;

  always_comb begin
    accept   = (state == IDLE) && bus.start;
    hs       = bus.out_valid && bus.out_ready;
    last_hs  = hs && bus.out_last;
    acc_rs   = bus.epoch_clr ? RAD_INIT : bus.radius;
    // In IDLE the level bank evaluates row 0 of the incoming winner so it registers on acceptance
    calc_row = (state == IDLE) ? '0 : bus.out_row + 1'b1;
    calc_x   = (state == IDLE) ? bus.win_x : wx_q;
    calc_y   = (state == IDLE) ? bus.win_y : wy_q;
    calc_rs  = (state == IDLE) ? acc_rs : rs_q;
  end

  for (genvar j = 0; j < MAP_W; j++) begin : g_col
    som_level_calc #(
      .COORD_W (COORD_W),
      .RAD_W   (RAD_W)
    ) u_level (
      .row   (calc_row),
      .col   (COORD_W'(j)),
      .win_x (calc_x),
      .win_y (calc_y),
      .rs    (calc_rs),
      .level (lvl[j])
    );
    assign sel_next[2*(MAP_W-1-j) +: 2] = lvl[j];
  end

  // Winner latch: data path, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      wx_q <= bus.win_x;
      wy_q <= bus.win_y;
      rs_q <= acc_rs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_row   <= '0;
      bus.out_sel   <= '0;
      bus.out_last  <= 1'b0;
      bus.radius    <= RAD_INIT;
      win_cnt       <= '0;
    end else begin
      // epoch_clr overrides any decay step landing in the same cycle
      if (bus.epoch_clr) begin
        bus.radius <= RAD_INIT;
        win_cnt    <= '0;
      end else if (last_hs) begin
        if (win_cnt == CNT_TOP) begin
          win_cnt <= '0;
          if (bus.radius > RAD_MIN)
            bus.radius <= bus.radius - 1'b1;
        end else begin
          win_cnt <= win_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state         <= SWEEP;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_row   <= calc_row;
            bus.out_sel   <= sel_next;
            bus.out_last  <= (calc_row == LAST_ROW);
          end
        end
        SWEEP: begin
          if (hs) begin
            if (bus.out_last) begin
              state         <= IDLE;
              bus.in_ready  <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              bus.out_row  <= calc_row;
              bus.out_sel  <= sel_next;
              bus.out_last <= (calc_row == LAST_ROW);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_som_neighbor_gen.sv
// Directed bench: default map (a), decaying-radius map (b) and a 4x4 map (c) on one clock.
module tb_som_neighbor_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  som_neighbor_gen_if #(.MAP_W(8), .COORD_W(3), .RAD_W(3)) a_if ();
  som_neighbor_gen_if #(.MAP_W(8), .COORD_W(3), .RAD_W(3)) b_if ();
  som_neighbor_gen_if #(.MAP_W(4), .COORD_W(2), .RAD_W(3)) c_if ();

  som_neighbor_gen #(
    .MAP_W(8), .MAP_H(8), .COORD_W(3), .RAD_W(3),
    .R_INIT(1), .R_MIN(1), .EPOCH_LEN(16)
  ) u_a (.clk(clk), .rst(rst), .bus(a_if));

  som_neighbor_gen #(
    .MAP_W(8), .MAP_H(8), .COORD_W(3), .RAD_W(3),
    .R_INIT(2), .R_MIN(1), .EPOCH_LEN(2)
  ) u_b (.clk(clk), .rst(rst), .bus(b_if));

  som_neighbor_gen #(
    .MAP_W(4), .MAP_H(4), .COORD_W(2), .RAD_W(3),
    .R_INIT(1), .R_MIN(1), .EPOCH_LEN(16)
  ) u_c (.clk(clk), .rst(rst), .bus(c_if));

  // Hand-derived rows for winner (3,3), radius 1
  logic [15:0] exp_a [8];
  logic [15:0] cap_b [8];
  int          rows_b;

  task automatic test_reset();
    int vcnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (a_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", a_if.in_ready); end
    n_checks++; if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", a_if.out_valid); end
    n_checks++; if (a_if.radius !== 3'd1) begin n_fail++; $display("FAIL reset_radius_a got=%0d want=1", a_if.radius); end
    n_checks++; if (a_if.out_row !== 3'd0 || a_if.out_sel !== 16'h0 || a_if.out_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs row=%0d sel=%h last=%b want 0/0000/0", a_if.out_row, a_if.out_sel, a_if.out_last); end
    n_checks++; if (b_if.radius !== 3'd2) begin n_fail++; $display("FAIL reset_radius_b got=%0d want=2", b_if.radius); end
    rst = 1'b0;
    // reset in the middle of a stalled sweep
    @(negedge clk);
    a_if.win_x = 3'd3; a_if.win_y = 3'd3; a_if.start = 1'b1; a_if.out_ready = 1'b0;
    @(negedge clk);
    a_if.start = 1'b0;
    n_checks++; if (a_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got=%b want=1", a_if.out_valid); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_idle valid=%b in_ready=%b want 0/1", a_if.out_valid, a_if.in_ready); end
    vcnt = 0;
    repeat (3) begin @(negedge clk); if (a_if.out_valid) vcnt++; end
    n_checks++; if (vcnt !== 0) begin n_fail++; $display("FAIL midrst_no_valid got=%0d valid cycles want=0", vcnt); end
    a_if.out_ready = 1'b1;
  endtask

  task automatic test_stream();
    @(negedge clk);
    a_if.win_x = 3'd3; a_if.win_y = 3'd3; a_if.start = 1'b1; a_if.out_ready = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (a_if.out_valid !== 1'b1 || a_if.out_row !== 3'(i) || a_if.out_last !== (i == 7) || a_if.out_sel !== exp_a[i]) begin
        n_fail++;
        $display("FAIL stream_row%0d valid=%b row=%0d last=%b sel=%h want 1/%0d/%b/%h",
                 i, a_if.out_valid, a_if.out_row, a_if.out_last, a_if.out_sel, i, (i == 7), exp_a[i]);
      end
      @(negedge clk);
    end
    n_checks++; if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stream_end valid=%b in_ready=%b want 0/1", a_if.out_valid, a_if.in_ready); end
  endtask

  task automatic test_backpressure();
    bit done;
    @(negedge clk);
    a_if.win_x = 3'd3; a_if.win_y = 3'd3; a_if.start = 1'b1; a_if.out_ready = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (a_if.out_row !== 3'd2 || a_if.out_sel !== 16'hE56F) begin
      n_fail++; $display("FAIL bp_row2 row=%0d sel=%h want 2/e56f", a_if.out_row, a_if.out_sel); end
    a_if.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (a_if.out_valid !== 1'b1 || a_if.out_row !== 3'd2 || a_if.out_sel !== 16'hE56F || a_if.out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d valid=%b row=%0d sel=%h last=%b want 1/2/e56f/0",
                 k, a_if.out_valid, a_if.out_row, a_if.out_sel, a_if.out_last);
      end
    end
    a_if.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (a_if.out_row !== 3'd3 || a_if.out_sel !== 16'hE46F) begin
      n_fail++; $display("FAIL bp_row3 row=%0d sel=%h want 3/e46f", a_if.out_row, a_if.out_sel); end
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      if (!a_if.out_valid) done = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL bp_drain valid=%b want 0 within 10 cycles", a_if.out_valid); end
  endtask

  task automatic test_start_ignored();
    int rows_ok;
    int extra;
    @(negedge clk);
    a_if.win_x = 3'd3; a_if.win_y = 3'd3; a_if.start = 1'b1; a_if.out_ready = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    rows_ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_if.out_valid && a_if.out_row == 3'(i) && a_if.out_sel == exp_a[i]) rows_ok++;
      a_if.start = (i == 3);
      a_if.win_x = (i == 3) ? 3'd0 : 3'd3;
      a_if.win_y = (i == 3) ? 3'd0 : 3'd3;
      @(negedge clk);
    end
    a_if.start = 1'b0;
    n_checks++; if (rows_ok !== 8) begin n_fail++; $display("FAIL ign_rows got=%0d matching rows want=8", rows_ok); end
    extra = 0;
    repeat (4) begin if (a_if.out_valid) extra++; @(negedge clk); end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ign_extra_sweep got=%0d valid cycles want=0", extra); end
  endtask

  // clr_mode: 0 none, 1 epoch_clr on last-row handshake, 2 epoch_clr while row 3 is presented
  task automatic sweep_b(input int clr_mode);
    bit done;
    @(negedge clk);
    b_if.win_x = 3'd0; b_if.win_y = 3'd0; b_if.start = 1'b1; b_if.out_ready = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    rows_b = 0;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      if (b_if.out_valid) begin
        cap_b[b_if.out_row] = b_if.out_sel;
        rows_b++;
        b_if.epoch_clr = (clr_mode == 1 && b_if.out_last) || (clr_mode == 2 && b_if.out_row == 3'd3);
        done = b_if.out_last;
      end
      @(negedge clk);
      b_if.epoch_clr = 1'b0;
    end
  endtask

  task automatic test_decay();
    sweep_b(0);
    n_checks++; if (rows_b !== 8 || cap_b[0] !== 16'h16BF) begin
      n_fail++; $display("FAIL decay_s1_row0 rows=%0d sel=%h want 8/16bf", rows_b, cap_b[0]); end
    n_checks++; if (b_if.radius !== 3'd2) begin n_fail++; $display("FAIL decay_s1_radius got=%0d want=2", b_if.radius); end
    sweep_b(0);
    n_checks++; if (b_if.radius !== 3'd1) begin n_fail++; $display("FAIL decay_s2_radius got=%0d want=1", b_if.radius); end
    sweep_b(0);
    n_checks++; if (cap_b[0] !== 16'h1BFF) begin n_fail++; $display("FAIL decay_s3_row0 got=%h want=1bff", cap_b[0]); end
    sweep_b(0);
    sweep_b(0);
    n_checks++; if (b_if.radius !== 3'd1) begin n_fail++; $display("FAIL decay_floor got=%0d want=1", b_if.radius); end
  endtask

  task automatic test_epoch_clr();
    @(negedge clk);
    b_if.epoch_clr = 1'b1;
    @(negedge clk);
    b_if.epoch_clr = 1'b0;
    n_checks++; if (b_if.radius !== 3'd2) begin n_fail++; $display("FAIL clr_idle_radius got=%0d want=2", b_if.radius); end
    sweep_b(0);
    sweep_b(1);
    n_checks++; if (b_if.radius !== 3'd2) begin n_fail++; $display("FAIL clr_on_last_radius got=%0d want=2", b_if.radius); end
    sweep_b(0);
    n_checks++; if (b_if.radius !== 3'd2) begin n_fail++; $display("FAIL clr_count_zero got=%0d want=2", b_if.radius); end
    sweep_b(0);
    n_checks++; if (b_if.radius !== 3'd1) begin n_fail++; $display("FAIL clr_then_decay got=%0d want=1", b_if.radius); end
    sweep_b(2);
    n_checks++; if (rows_b !== 8 || cap_b[1] !== 16'h5BFF || cap_b[4] !== 16'hFFFF) begin
      n_fail++; $display("FAIL clr_mid_rows rows=%0d r1=%h r4=%h want 8/5bff/ffff", rows_b, cap_b[1], cap_b[4]); end
    n_checks++; if (b_if.radius !== 3'd2) begin n_fail++; $display("FAIL clr_mid_radius got=%0d want=2", b_if.radius); end
  endtask

  task automatic test_small_map();
    logic [7:0] exp_c [4];
    exp_c = '{8'b10_01_01_01, 8'b10_01_00_01, 8'b10_01_01_01, 8'b10_10_10_10};
    @(negedge clk);
    c_if.win_x = 2'd1; c_if.win_y = 2'd2; c_if.start = 1'b1; c_if.out_ready = 1'b1;
    @(negedge clk);
    c_if.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (c_if.out_valid !== 1'b1 || c_if.out_row !== 2'(i) || c_if.out_last !== (i == 3) || c_if.out_sel !== exp_c[i]) begin
        n_fail++;
        $display("FAIL small_row%0d valid=%b row=%0d last=%b sel=%b want 1/%0d/%b/%b",
                 i, c_if.out_valid, c_if.out_row, c_if.out_last, c_if.out_sel, i, (i == 3), exp_c[i]);
      end
      @(negedge clk);
    end
    n_checks++; if (c_if.out_valid !== 1'b0 || c_if.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL small_end valid=%b in_ready=%b want 0/1", c_if.out_valid, c_if.in_ready); end
  endtask

  initial begin
    exp_a = '{16'hFFFF, 16'hEAAF, 16'hE56F, 16'hE46F, 16'hE56F, 16'hEAAF, 16'hFFFF, 16'hFFFF};
    a_if.start = 1'b0; a_if.win_x = '0; a_if.win_y = '0; a_if.epoch_clr = 1'b0; a_if.out_ready = 1'b1;
    b_if.start = 1'b0; b_if.win_x = '0; b_if.win_y = '0; b_if.epoch_clr = 1'b0; b_if.out_ready = 1'b1;
    c_if.start = 1'b0; c_if.win_x = '0; c_if.win_y = '0; c_if.epoch_clr = 1'b0; c_if.out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_start_ignored();
    test_decay();
    test_epoch_clr();
    test_small_map();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
